aes_decipher_block: RTL

Iterative AES block decipher engine: it turns one 128-bit ciphertext block into plaintext, processing one full round per clock. It is the inverse-direction counterpart of the encipher round datapath and sits between the core control/register interface and the key-expansion memory. It requests round keys by index and receives them combinationally. SubBytes inversion uses 16 instances of the combinational `aes_inv_sbox` (8-bit addr in, 8-bit data out).

---
 rtl/aes_decipher_block.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/aes_decipher_block.sv
// Iterative AES-128/256 block decipher: one full inverse round per clock,
// round keys fetched by index from an external key memory.

module aes_inv_sbox (
  input  logic [7:0] addr,
  output logic [7:0] data
);
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign data = INV_SBOX[addr];
endmodule

module aes_decipher_block (
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic         keylen,
  input  logic [127:0] block,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [127:0] new_block,
  output logic         ready,
  output logic         valid
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] INIT  = 2'd1;
  localparam logic [1:0] MAIN  = 2'd2;
  localparam logic [1:0] FINAL = 2'd3;

  logic [1:0]   fsm_q;
  logic [3:0]   round_ctr;
  logic [127:0] state_q;
  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] keyed;
  logic [127:0] mixed;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m09 [4];
    logic [7:0] m0b [4];
    logic [7:0] m0d [4];
    logic [7:0] m0e [4];
    for (int i = 0; i < 4; i++) begin
      a[i]   = col[31-8*i -: 8];
      x2[i]  = xtime(a[i]);
      x4[i]  = xtime(x2[i]);
      x8[i]  = xtime(x4[i]);
      m09[i] = x8[i] ^ a[i];
      m0b[i] = x8[i] ^ x2[i] ^ a[i];
      m0d[i] = x8[i] ^ x4[i] ^ a[i];
      m0e[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3],
            m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3],
            m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3],
            m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3]};
  endfunction

  // Byte (r,c) sits at bit offset 127-8*(4c+r); row r rotates right by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = 4 * c + r;
      localparam int SRC = 4 * ((c - r + 4) % 4) + r;
      assign shifted[127-8*DST -: 8] = state_q[127-8*SRC -: 8];
      aes_inv_sbox u_inv_sbox (
        .addr (shifted[127-8*DST -: 8]),
        .data (subbed[127-8*DST -: 8])
      );
    end
    assign mixed[127-32*c -: 32] = inv_mix_column(keyed[127-32*c -: 32]);
  end

  assign keyed = subbed ^ round_key;
  assign round = (fsm_q == INIT || fsm_q == MAIN) ? round_ctr : 4'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q     <= IDLE;
      round_ctr <= 4'd0;
      new_block <= 128'd0;
      ready     <= 1'b1;
      valid     <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (next) begin
            round_ctr <= keylen ? 4'd14 : 4'd10;
            valid     <= 1'b0;
            ready     <= 1'b0;
            fsm_q     <= INIT;
          end
        end
        INIT: begin
          round_ctr <= round_ctr - 4'd1;
          fsm_q     <= MAIN;
        end
        MAIN: begin
          round_ctr <= round_ctr - 4'd1;
          if (round_ctr == 4'd1) fsm_q <= FINAL;
        end
        FINAL: begin
          new_block <= keyed;
          valid     <= 1'b1;
          ready     <= 1'b1;
          fsm_q     <= IDLE;
        end
      endcase
    end
  end

  // NOTE: the datapath register has no reset; it is always loaded from block before use.
  always_ff @(posedge clk) begin
    case (fsm_q)
      IDLE:    if (next) state_q <= block;
      INIT:    state_q <= state_q ^ round_key;
      MAIN:    state_q <= mixed;
      default: state_q <= state_q;
    endcase
  end
endmodule
